// File: rtl/ball_pkg.sv
// Shared definitions for the ball-thrower game: state encodings, field widths
// and default frame constants used by the sequencer and its neighbours.
package ball_pkg;

    localparam int VEL_W   = 3;
    localparam int ANG_W   = 5;
    localparam int SCORE_W = 4;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_AIM    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LAUNCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_FLIGHT = 3'd2;
    localparam logic [STATE_W-1:0] ST_LANDED = 3'd3;
    localparam logic [STATE_W-1:0] ST_OVER   = 3'd4;

    localparam int DEF_LAND_HOLD_FRAMES = 60;
    localparam int DEF_FLIGHT_TIMEOUT   = 600;
    localparam int DEF_MAX_THROWS       = 5;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/go_sync.sv
// Two-flop synchronizer for an asynchronous level input, followed by a
// rising-edge detector; reusable for the board KEY inputs.
module go_sync (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/throw_sequencer.sv
// Frame-synchronous throw sequencer: arms aiming, latches power/angle on launch,
// runs one flight, scores it, holds the result and ends the game after N throws.
module throw_sequencer
    import ball_pkg::*;
#(
    parameter int LAND_HOLD_FRAMES = DEF_LAND_HOLD_FRAMES,
    parameter int FLIGHT_TIMEOUT   = DEF_FLIGHT_TIMEOUT,
    parameter int MAX_THROWS       = DEF_MAX_THROWS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               go,
    input  logic [VEL_W-1:0]   vel_in,
    input  logic [ANG_W-1:0]   ang_in,
    input  logic               ball_landed,
    input  logic               ball_hit,
    output logic               aim_en,
    output logic               launch,
    output logic [VEL_W-1:0]   vel_lat,
    output logic [ANG_W-1:0]   ang_lat,
    output logic               ball_run,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         throws,
    output logic               game_over,
    output logic [STATE_W-1:0] state
);

    localparam logic [9:0] FLIGHT_LAST = 10'(FLIGHT_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(LAND_HOLD_FRAMES);
    localparam logic [2:0] THROWS_LAST = 3'(MAX_THROWS);

    logic go_rise;

    logic [STATE_W-1:0] state_q, state_d;
    logic [VEL_W-1:0]   vel_lat_q, vel_lat_d;
    logic [ANG_W-1:0]   ang_lat_q, ang_lat_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         throws_q, throws_d;
    logic [9:0]         flight_cnt_q, flight_cnt_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               go_pend_q, go_pend_d;
    logic               aim_en_q, launch_q, ball_run_q, game_over_q;

    go_sync u_go_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (go),
        .rise_o (go_rise)
    );

    // NOTE: every variable gets a default at the top of always_comb; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        vel_lat_d    = vel_lat_q;
        ang_lat_d    = ang_lat_q;
        score_d      = score_q;
        throws_d     = throws_q;
        flight_cnt_d = flight_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        go_pend_d    = go_pend_q | go_rise;

        case (state_q)
            ST_AIM: begin
                // Only a request already pending before this tick is acted on.
                if (frame_tick && go_pend_q) begin
                    if (vel_in != '0) begin
                        vel_lat_d = vel_in;
                        ang_lat_d = ang_in;
                        state_d   = ST_LAUNCH;
                    end else begin
                        go_pend_d = 1'b0;
                    end
                end
            end
            ST_LAUNCH: begin
                flight_cnt_d = '0;
                state_d      = ST_FLIGHT;
            end
            ST_FLIGHT: begin
                if (frame_tick) begin
                    if (ball_hit) begin
                        score_d = sat_inc(score_q);
                        state_d = ST_LANDED;
                    end else if (ball_landed || flight_cnt_q == FLIGHT_LAST) begin
                        state_d = ST_LANDED;
                    end else begin
                        flight_cnt_d = flight_cnt_q + 10'd1;
                    end
                end
            end
            ST_LANDED: begin
                if (frame_tick) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    if (hold_cnt_d == HOLD_LAST) begin
                        state_d = (throws_q == THROWS_LAST) ? ST_OVER : ST_AIM;
                    end
                end
            end
            ST_OVER: begin
                if (go_rise) begin
                    score_d  = '0;
                    throws_d = '0;
                    state_d  = ST_AIM;
                end
            end
            default: state_d = ST_AIM;
        endcase

        if (state_d == ST_LANDED && state_q != ST_LANDED) begin
            throws_d   = throws_q + 3'd1;
            hold_cnt_d = '0;
        end

        // A request never survives a state change or an in-flight throw.
        if (state_d != state_q || state_q == ST_LAUNCH || state_q == ST_FLIGHT ||
            state_q == ST_LANDED) begin
            go_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_AIM;
            vel_lat_q    <= '0;
            ang_lat_q    <= '0;
            score_q      <= '0;
            throws_q     <= '0;
            flight_cnt_q <= '0;
            hold_cnt_q   <= '0;
            go_pend_q    <= 1'b0;
            aim_en_q     <= 1'b1;
            launch_q     <= 1'b0;
            ball_run_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vel_lat_q    <= vel_lat_d;
            ang_lat_q    <= ang_lat_d;
            score_q      <= score_d;
            throws_q     <= throws_d;
            flight_cnt_q <= flight_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            go_pend_q    <= go_pend_d;
            aim_en_q     <= (state_d == ST_AIM);
            launch_q     <= (state_d == ST_LAUNCH);
            ball_run_q   <= (state_d == ST_FLIGHT);
            game_over_q  <= (state_d == ST_OVER);
        end
    end

    assign state     = state_q;
    assign vel_lat   = vel_lat_q;
    assign ang_lat   = ang_lat_q;
    assign score     = score_q;
    assign throws    = throws_q;
    assign aim_en    = aim_en_q;
    assign launch    = launch_q;
    assign ball_run  = ball_run_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_throw_sequencer.sv
// Directed testbench for throw_sequencer with hand-computed expectations
// (LAND_HOLD_FRAMES=60, FLIGHT_TIMEOUT=4, MAX_THROWS=5).
module tb_throw_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       go = 1'b0;
    logic [2:0] vel_in = '0;
    logic [4:0] ang_in = '0;
    logic       ball_landed = 1'b0;
    logic       ball_hit = 1'b0;
    logic       aim_en, launch, ball_run, game_over;
    logic [2:0] vel_lat, throws, state;
    logic [4:0] ang_lat;
    logic [3:0] score;

    int n_tests = 0;
    int n_fail  = 0;

    throw_sequencer #(
        .LAND_HOLD_FRAMES (60),
        .FLIGHT_TIMEOUT   (4),
        .MAX_THROWS       (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .go          (go),
        .vel_in      (vel_in),
        .ang_in      (ang_in),
        .ball_landed (ball_landed),
        .ball_hit    (ball_hit),
        .aim_en      (aim_en),
        .launch      (launch),
        .vel_lat     (vel_lat),
        .ang_lat     (ang_lat),
        .ball_run    (ball_run),
        .score       (score),
        .throws      (throws),
        .game_over   (game_over),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // go_pend is set three edges after go rises; lower go afterwards.
    task automatic pulse_go();
        go = 1'b1;
        repeat (4) step();
        go = 1'b0;
        repeat (2) step();
    endtask

    task automatic hold_frames(input int n);
        repeat (n) frame();
    endtask

    // Leaves the DUT in FLIGHT.
    task automatic do_launch(input logic [2:0] v, input logic [4:0] a);
        vel_in = v;
        ang_in = a;
        pulse_go();
        frame();
        step();
    endtask

    initial begin
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_ball_run", ball_run, 0);
        rst = 1'b0;
        step();
        check("rst_aim_en", aim_en, 1);
        check("rst_launch", launch, 0);
        check("rst_score", score, 0);
        check("rst_throws", throws, 0);
        check("rst_game_over", game_over, 0);
        check("rst_vel_lat", vel_lat, 0);

        // Throw 1: launch, then timeout miss.
        vel_in = 3'd5;
        ang_in = 5'd12;
        pulse_go();
        check("pre_tick_state", state, 0);
        frame();
        check("launch_pulse", launch, 1);
        check("launch_state", state, 1);
        check("launch_vel_lat", vel_lat, 5);
        check("launch_ang_lat", ang_lat, 12);
        check("launch_no_run", ball_run, 0);
        step();
        check("launch_drop", launch, 0);
        check("flight_run", ball_run, 1);
        check("flight_state", state, 2);
        check("flight_aim_en", aim_en, 0);
        vel_in = 3'd2;
        ang_in = 5'd3;
        hold_frames(3);
        check("timeout_3rd", state, 2);
        frame();
        check("timeout_4th", state, 3);
        check("timeout_score", score, 0);
        check("timeout_throws", throws, 1);
        check("timeout_run_off", ball_run, 0);
        check("vel_lat_held", vel_lat, 5);
        check("ang_lat_held", ang_lat, 12);
        hold_frames(59);
        check("hold_59", state, 3);
        frame();
        check("hold_60", state, 0);
        check("hold_aim_en", aim_en, 1);

        // Zero-power rejection, then a valid launch (throw 2).
        vel_in = 3'd0;
        pulse_go();
        frame();
        check("zero_state", state, 0);
        check("zero_launch", launch, 0);
        vel_in = 3'd3;
        frame();
        check("zero_pend_cleared", state, 0);
        pulse_go();
        frame();
        check("relaunch_state", state, 1);
        check("relaunch_vel", vel_lat, 3);
        step();

        // Hit and landed together count as a hit.
        ball_hit = 1'b1;
        ball_landed = 1'b1;
        frame();
        ball_hit = 1'b0;
        ball_landed = 1'b0;
        check("both_state", state, 3);
        check("both_score", score, 1);
        check("both_throws", throws, 2);
        hold_frames(60);
        check("both_back_aim", state, 0);

        // go_rise coinciding with frame_tick waits for the next tick (throw 3).
        vel_in = 3'd6;
        go = 1'b1;
        step();
        step();
        frame();
        check("rise_tick_state", state, 0);
        frame();
        go = 1'b0;
        check("rise_next_tick", state, 1);
        step();

        // Preload score to 14, then two hits saturate at 15.
        force dut.score_q = 4'd14;
        step();
        step();
        release dut.score_q;
        step();
        check("preload_score", score, 14);
        ball_hit = 1'b1;
        frame();
        ball_hit = 1'b0;
        check("hit_to_15", score, 15);
        check("throws_3", throws, 3);
        hold_frames(60);
        do_launch(3'd1, 5'd31);
        check("throw4_flight", state, 2);
        ball_hit = 1'b1;
        frame();
        ball_hit = 1'b0;
        check("sat_score", score, 15);
        check("throws_4", throws, 4);
        hold_frames(60);

        // Throw 5 lands; game over after the hold.
        do_launch(3'd7, 5'd0);
        ball_landed = 1'b1;
        frame();
        ball_landed = 1'b0;
        check("land_score", score, 15);
        check("throws_5", throws, 5);
        hold_frames(60);
        check("over_state", state, 4);
        check("over_flag", game_over, 1);
        check("over_aim_en", aim_en, 0);
        pulse_go();
        check("newgame_state", state, 0);
        check("newgame_score", score, 0);
        check("newgame_throws", throws, 0);
        check("newgame_over", game_over, 0);
        frame();
        check("newgame_no_launch", state, 0);

        // Asynchronous reset mid-flight.
        do_launch(3'd4, 5'd9);
        ball_hit = 1'b1;
        frame();
        ball_hit = 1'b0;
        hold_frames(60);
        do_launch(3'd2, 5'd5);
        check("pre_rst_run", ball_run, 1);
        #2 rst = 1'b1;
        #1;
        check("async_run", ball_run, 0);
        check("async_state", state, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_aim_en", aim_en, 1);
        check("post_rst_score", score, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
